// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. Logic and add/sub ops finish in one cycle.
// Multiply (shift-add) and divide (restoring) are iterative and take WIDTH cycles.
// Ports:
//   clk, rst                       clock and sync active-high reset
//   in_valid/in_ready, op, operand_1, operand_2   request side
//   out_valid/out_ready, result, result_hi, flag_*  response side
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dz
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  // mul: {high, low} partial product
  // div: {remainder, dividend/quotient shift reg}
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   sc_res;
  logic [WIDTH-1:0]   sc_hi;
  logic               sc_c;
  logic               sc_v;
  logic               sc_dz;
  logic               is_long;

  always_comb begin
    sum    = {1'b0, operand_1} + {1'b0, operand_2};
    diff   = {1'b0, operand_1} - {1'b0, operand_2};
    sc_res = '0;
    sc_hi  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_dz  = 1'b0;
    case (op)
      OP_PASS: sc_res = operand_1;
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (operand_1[WIDTH-1] == operand_2[WIDTH-1])
               && (sum[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        // the extra top bit is set exactly when A < B
        sc_c   = diff[WIDTH];
        sc_v   = (operand_1[WIDTH-1] != operand_2[WIDTH-1])
               && (diff[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_MUL: sc_res = '0;
      OP_DIV: begin
        sc_res = '1;
        sc_hi  = operand_1;
        sc_dz  = 1'b1;
      end
      OP_AND: sc_res = operand_1 & operand_2;
      OP_OR:  sc_res = operand_1 | operand_2;
      OP_NOT: sc_res = ~operand_1;
      default: sc_res = '0;
    endcase
    is_long = ((op == OP_MUL) || (op == OP_DIV))
            && (operand_2 != '0);
  end

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] nxt;

  always_comb begin
    // add the multiplicand into the high half, then shift right
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (b_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    // bring down the next dividend bit and try subtracting B
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, b_q};
    div_rem   = div_ge ? WIDTH'(div_trial - {1'b0, b_q})
                       : div_trial[WIDTH-1:0];
    div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
    nxt       = is_div ? div_next : mul_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_div     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result     <= '0;
      result_hi  <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      flag_dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_long) begin
              a_q    <= operand_1;
              b_q    <= operand_2;
              is_div <= (op == OP_DIV);
              acc    <= (op == OP_DIV)
                      ? {{WIDTH{1'b0}}, operand_1} : '0;
              cnt    <= CW'(WIDTH);
              state  <= BUSY;
            end else begin
              result     <= sc_res;
              result_hi  <= sc_hi;
              flag_zero  <= (sc_res == '0);
              flag_carry <= sc_c;
              flag_ovf   <= sc_v;
              flag_dz    <= sc_dz;
              out_valid  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        BUSY: begin
          acc <= nxt;
          cnt <= cnt - CW'(1);
          if (!is_div) b_q <= b_q >> 1;
          // last iteration: publish the freshly computed value
          if (cnt == CW'(1)) begin
            result     <= nxt[WIDTH-1:0];
            result_hi  <= nxt[2*WIDTH-1:WIDTH];
            flag_zero  <= (nxt[WIDTH-1:0] == '0);
            flag_carry <= !is_div
                       && (nxt[2*WIDTH-1:WIDTH] != '0);
            flag_ovf   <= 1'b0;
            flag_dz    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            result     <= '0;
            result_hi  <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_dz    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=8.
// Directed cases plus random ops against a reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_ovf;
  logic         flag_dz;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .operand_1  (a),
    .operand_2  (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .flag_dz    (flag_dz)
  );

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic       z;
    logic       c;
    logic       v;
    logic       dz;
    int         lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input string what,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h",
               tag, what, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] r, input logic [7:0] h,
                              input logic z, input logic c,
                              input logic v, input logic d,
                              input int l);
    exp_t e;
    e.res = r; e.hi = h; e.z = z; e.c = c;
    e.v = v; e.dz = d; e.lat = l;
    return e;
  endfunction

  function automatic exp_t model(input logic [2:0] o,
                                 input logic [7:0] x,
                                 input logic [7:0] y);
    exp_t e;
    int sx, sy, sr, ux, uy;
    logic [15:0] p;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    e = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    case (o)
      3'd0: e.res = x;
      3'd1: begin
        e.res = 8'(ux + uy);
        e.c   = (ux + uy) > 255;
        sr    = sx + sy;
        e.v   = (sr > 127) || (sr < -128);
      end
      3'd2: begin
        e.res = 8'(ux - uy);
        e.c   = ux < uy;
        sr    = sx - sy;
        e.v   = (sr > 127) || (sr < -128);
      end
      3'd3: begin
        p     = 16'(ux * uy);
        e.res = p[7:0];
        e.hi  = p[15:8];
        e.c   = p[15:8] != 8'h00;
        e.lat = (y != 0) ? 9 : 1;
      end
      3'd4: begin
        if (y == 0) begin
          e.res = 8'hFF;
          e.hi  = x;
          e.dz  = 1'b1;
        end else begin
          e.res = 8'(ux / uy);
          e.hi  = 8'(ux % uy);
          e.lat = 9;
        end
      end
      3'd5: e.res = x & y;
      3'd6: e.res = x | y;
      default: e.res = ~x;
    endcase
    e.z = (e.res == 8'h00);
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [7:0] x, input logic [7:0] y,
                        input exp_t e);
    int   n;
    exp_t q;
    check(tag, "in_ready", in_ready, 1);
    in_valid = 1'b1;
    op = o; a = x; b = y;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // operand changes after accept must not matter
    a = 8'($urandom);
    b = 8'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    q = sb.pop_front();
    check(tag, "latency", n, q.lat);
    check(tag, "out_valid", out_valid, 1);
    check(tag, "busy_rdy", in_ready, 0);
    check(tag, "result", result, q.res);
    check(tag, "result_hi", result_hi, q.hi);
    check(tag, "zero", flag_zero, q.z);
    check(tag, "carry", flag_carry, q.c);
    check(tag, "ovf", flag_ovf, q.v);
    check(tag, "dz", flag_dz, q.dz);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check(tag, "drain_valid", out_valid, 0);
    check(tag, "drain_rdy", in_ready, 1);
  endtask

  initial begin
    logic [2:0] ro;
    logic [7:0] rx, ry;
    rst = 1'b1;
    in_valid = 1'b1;
    op = 3'd1; a = 8'h11; b = 8'h22;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", "in_ready", in_ready, 1);
    check("reset", "out_valid", out_valid, 0);
    check("reset", "result", result, 0);
    check("reset", "result_hi", result_hi, 0);
    check("reset", "flags",
          {flag_zero, flag_carry, flag_ovf, flag_dz}, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst", "out_valid", out_valid, 0);

    run_op("add_c", 3'd1, 8'hF0, 8'h20, mk(8'h10, 8'h00, 0, 1, 0, 0, 1));
    run_op("add_v", 3'd1, 8'h7F, 8'h01, mk(8'h80, 8'h00, 0, 0, 1, 0, 1));
    run_op("sub_b", 3'd2, 8'h05, 8'h07, mk(8'hFE, 8'h00, 0, 1, 0, 0, 1));
    run_op("sub_z", 3'd2, 8'h33, 8'h33, mk(8'h00, 8'h00, 1, 0, 0, 0, 1));
    run_op("mul_ff", 3'd3, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 0, 1, 0, 0, 9));
    run_op("mul_0", 3'd3, 8'h12, 8'h00, mk(8'h00, 8'h00, 1, 0, 0, 0, 1));
    run_op("div", 3'd4, 8'd200, 8'd7, mk(8'h1C, 8'h04, 0, 0, 0, 0, 9));
    run_op("div_0", 3'd4, 8'h55, 8'h00, mk(8'hFF, 8'h55, 0, 0, 0, 1, 1));
    run_op("pass", 3'd0, 8'hA5, 8'h3C, mk(8'hA5, 8'h00, 0, 0, 0, 0, 1));
    run_op("not", 3'd7, 8'hFF, 8'h3C, mk(8'h00, 8'h00, 1, 0, 0, 0, 1));

    // backpressure: result must hold and new requests stay refused
    in_valid = 1'b1;
    op = 3'd5; a = 8'hCC; b = 8'hAA;
    @(posedge clk); #1;
    check("bp", "valid", out_valid, 1);
    op = 3'd1; a = 8'h01; b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp", "hold_res", result, 8'h88);
      check("bp", "hold_rdy", in_ready, 0);
      check("bp", "hold_vld", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp", "rel_rdy", in_ready, 1);
    check("bp", "rel_vld", out_valid, 0);
    run_op("bp_next", 3'd6, 8'h30, 8'h03, mk(8'h33, 8'h00, 0, 0, 0, 0, 1));

    // reset in the middle of a divide discards it
    in_valid = 1'b1;
    op = 3'd4; a = 8'd100; b = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_div", "in_ready", in_ready, 1);
    check("rst_div", "out_valid", out_valid, 0);
    check("rst_div", "result", result, 0);
    check("rst_div", "result_hi", result_hi, 0);
    check("rst_div", "flags",
          {flag_zero, flag_carry, flag_ovf, flag_dz}, 0);
    repeat (12) @(posedge clk);
    #1;
    check("rst_div", "no_output", out_valid, 0);
    run_op("or", 3'd6, 8'h0F, 8'hF0, mk(8'hFF, 8'h00, 0, 0, 0, 0, 1));

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = 8'($urandom);
      ry = (i % 6 == 0) ? 8'h00 : 8'($urandom);
      run_op("rand", ro, rx, ry, model(ro, rx, ry));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational ALU used in the execute path. Logic ops and add/sub complete in one cycle. Multiply and divide run as iterative multi-cycle operations, and the block reports their full-width results together with status flags. Sits between the decode/operand-fetch stage and writeback; both sides use valid/ready handshakes, so the pipeline can stall on long operations.

## Interface
- WIDTH, 8: operand/result width in bits (≥2).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- op  input  3  opcode: 000 pass A, 001 add, 010 sub, 011 mul, 100 div, 101 and, 110 or, 111 not A.
- operand_1  input  WIDTH  A, unsigned.
- operand_2  input  WIDTH  B, unsigned.
- out_valid  output  1  result valid; held until out_ready.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  primary result (sum/diff/product low/quotient/logic).
- result_hi  output  WIDTH  product high word (mul), remainder (div), else 0.
- flag_zero  output  1  result == 0 (result only, not result_hi).
- flag_carry  output  1  add carry-out; sub borrow (A < B); mul: result_hi ≠ 0; else 0.
- flag_ovf  output  1  signed (two's-complement) overflow for add/sub; else 0.
- flag_dz  output  1  divide by zero (div with B == 0); else 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid, latch op, A and B (accept).
  - mul with B≠0, or div with B≠0 → BUSY, counter = WIDTH.
  - All other ops, mul with B==0, and div with B==0 → compute, register outputs, → DONE.
- BUSY: one iteration per cycle; counter decrements. When counter reaches 0, register outputs → DONE.
  - mul: shift-add over B bits, 2·WIDTH accumulator; result = low word, result_hi = high word.
  - div: restoring divide, one quotient bit per cycle MSB first; result = quotient, result_hi = remainder.
- DONE: out_valid=1; outputs stable. On out_ready → IDLE.
- Inputs are ignored outside the IDLE accept cycle. Changing operand_1/operand_2 mid-operation has no effect.
- Width rules:
  - add/sub wrap modulo 2^WIDTH.
  - mul full 2·WIDTH product. B==0 short-circuits to 0/0.
  - not A = bitwise invert.
- Div by zero: result = all ones, result_hi = A, flag_dz=1, 1-cycle latency.
- Flags are registered with result and valid only while out_valid=1.

## Timing
- Reset (rst=1 at clk edge): state=IDLE, counter=0, in_ready=1, out_valid=0, result=0, result_hi=0, all flags 0. Reset overrides any BUSY/DONE state; an in-flight op is discarded with no output.
- Single-cycle ops: accepted at edge N, out_valid=1 from edge N+1.
- mul/div (B≠0): accepted at edge N, out_valid=1 from edge N+WIDTH+1.
- out_valid and in_ready are never both 1; at most one op is in flight.
- DONE with out_ready=1 at edge M: out_valid=0 and in_ready=1 after M. The next accept is possible at edge M+1, so back-to-back single-cycle throughput is one op per 2 cycles.
- out_ready held low: DONE persists indefinitely with outputs unchanged.
- in_valid in the same cycle as rst: ignored.

## Test plan
- WIDTH=8, add 0xF0+0x20 → result 0x10, carry=1, ovf=0, zero=0, out_valid one cycle after accept; add 0x7F+0x01 → 0x80, ovf=1, carry=0.
- sub 0x05−0x07 → result 0xFE, carry(borrow)=1, zero=0; sub 0x33−0x33 → 0x00, zero=1, carry=0.
- mul 0xFF×0xFF → result 0x01, result_hi 0xFE, carry=1, out_valid exactly 9 cycles after accept; mul 0x12×0x00 → 0/0, 1 cycle.
- div 200÷7 → result 28 (0x1C), result_hi 4, out_valid 9 cycles after accept; div 0x55÷0 → result 0xFF, result_hi 0x55, flag_dz=1, 1 cycle.
- Backpressure: and 0xCC&0xAA with out_ready=0 for 5 cycles → result 0x88 held, in_ready=0, and a new in_valid is not accepted; after out_ready pulse → IDLE, next op accepted the following cycle.
- Reset mid-divide: assert rst 3 cycles into div 100÷3 → next cycle IDLE, out_valid=0, all outputs 0; a subsequent or 0x0F|0xF0 → 0xFF, 1 cycle.
